// File: rtl/div_ctrl.sv
// Run-time controlled counter divider: valid/ready ratio updates applied on period boundaries.
// Optional `periods` output counter is enabled by defining DIV_CTRL_PERIOD_CNT_EN.
module div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             flag_out,
`ifdef DIV_CTRL_PERIOD_CNT_EN
    output logic             busy,
    output logic [15:0]      periods
`else
    output logic             busy
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] ratio, ratio_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             xfer, cfg_legal, wrap;
    logic             clk_nxt, flag_nxt, busy_nxt, err_nxt;

    assign cfg_ready = (state == IDLE) || !pend_valid;

    // Next-state, counter, ratio/pending-slot and output decode; outputs are
    // derived from the post-edge state so they are registered yet aligned.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ratio_nxt      = ratio;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;

        xfer      = cfg_valid && cfg_ready;
        cfg_legal = (cfg_div >= CNT_W'(2));
        wrap      = (state != IDLE) && (cnt == (ratio - CNT_W'(1)));

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
                if (!enable) state_nxt = STOP;
            end
            STOP: begin
                cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
                if (wrap) state_nxt = enable ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A slot filled in the wrap cycle itself was empty before, so it waits for the next wrap.
        if (wrap && pend_valid) begin
            ratio_nxt      = pend_div;
            pend_valid_nxt = 1'b0;
        end

        if (xfer && cfg_legal) begin
            if (state == IDLE) begin
                ratio_nxt = cfg_div;
            end else begin
                pend_div_nxt   = cfg_div;
                pend_valid_nxt = 1'b1;
            end
        end

        busy_nxt = (state_nxt != IDLE);
        clk_nxt  = busy_nxt && (cnt_nxt < (ratio_nxt >> 1));
        flag_nxt = busy_nxt && (cnt_nxt == '0);
        err_nxt  = xfer && !cfg_legal;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ratio      <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            clk_out    <= 1'b0;
            flag_out   <= 1'b0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ratio      <= ratio_nxt;
            pend_div   <= pend_div_nxt;
            pend_valid <= pend_valid_nxt;
            clk_out    <= clk_nxt;
            flag_out   <= flag_nxt;
            cfg_err    <= err_nxt;
            busy       <= busy_nxt;
        end
    end

`ifdef DIV_CTRL_PERIOD_CNT_EN
    // Saturating count of completed periods.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            periods <= 16'h0000;
        end else if (wrap && (periods != 16'hFFFF)) begin
            periods <= periods + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl (default CNT_W=16, DEFAULT_DIV=8).
// Also checks the `periods` output when DIV_CTRL_PERIOD_CNT_EN is defined.
module tb_div_ctrl;

    logic        clk_in;
    logic        rst;
    logic        enable;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_out;
    logic        flag_out;
    logic        busy;
`ifdef DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] periods;
`endif

    int n_cmp = 0;
    int n_err = 0;

    div_ctrl #(.CNT_W(16), .DEFAULT_DIV(8)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .flag_out  (flag_out),
`ifdef DIV_CTRL_PERIOD_CNT_EN
        .busy      (busy),
        .periods   (periods)
`else
        .busy      (busy)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [15:0] div);
        enable    = en;
        cfg_valid = valid;
        cfg_div   = div;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then compare against the ideal waveform for counter value c under ratio n.
    task automatic runCycle(input string tag, input int c, input int n, input logic bsy);
        step();
        checkOutput({tag, ".clk"},  {15'd0, clk_out},  {15'd0, (c < n / 2)});
        checkOutput({tag, ".flag"}, {15'd0, flag_out}, {15'd0, (c == 0)});
        checkOutput({tag, ".busy"}, {15'd0, busy},     {15'd0, bsy});
    endtask

    task automatic idleCycle(input string tag);
        step();
        checkOutput({tag, ".clk"},  {15'd0, clk_out},  16'd0);
        checkOutput({tag, ".flag"}, {15'd0, flag_out}, 16'd0);
        checkOutput({tag, ".busy"}, {15'd0, busy},     16'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".clk"},   {15'd0, clk_out},   16'd0);
        checkOutput({tag, ".flag"},  {15'd0, flag_out},  16'd0);
        checkOutput({tag, ".busy"},  {15'd0, busy},      16'd0);
        checkOutput({tag, ".err"},   {15'd0, cfg_err},   16'd0);
        checkOutput({tag, ".ready"}, {15'd0, cfg_ready}, 16'd1);
`ifdef DIV_CTRL_PERIOD_CNT_EN
        checkOutput({tag, ".periods"}, periods, 16'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0);
        step();
        step();
        checkResetOutputs("reset");
        rst = 1'b0;

        $display("[TB] default ratio 8 run");
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 16; k++) runCycle("div8", k % 8, 8, 1'b1);

        $display("[TB] illegal ratio while running");
        applyStimulus(1'b1, 1'b1, 16'd1);
        runCycle("err", 0, 8, 1'b1);
        checkOutput("err.pulse", {15'd0, cfg_err}, 16'd1);
        checkOutput("err.ready", {15'd0, cfg_ready}, 16'd1);
        applyStimulus(1'b1, 1'b0, 16'd0);
        runCycle("err", 1, 8, 1'b1);
        checkOutput("err.clear", {15'd0, cfg_err}, 16'd0);
        runCycle("err", 2, 8, 1'b1);
        runCycle("err", 3, 8, 1'b1);

        $display("[TB] stop at cnt 3");
        applyStimulus(1'b0, 1'b0, 16'd0);
        for (int c = 4; c < 8; c++) runCycle("stop", c, 8, 1'b1);
        idleCycle("stop.idle");
        checkOutput("stop.ready", {15'd0, cfg_ready}, 16'd1);
        idleCycle("stop.idle2");

        $display("[TB] re-enable during STOP");
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int c = 0; c < 3; c++) runCycle("rerun", c, 8, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0);
        for (int c = 3; c < 6; c++) runCycle("rerun.stop", c, 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'd0);
        runCycle("rerun.back", 6, 8, 1'b1);
        runCycle("rerun.back", 7, 8, 1'b1);
        for (int c = 0; c < 8; c++) runCycle("rerun.cont", c, 8, 1'b1);
        runCycle("rerun.cont", 0, 8, 1'b1);

        $display("[TB] ratio change 8 -> 4 at cnt 2");
        runCycle("chg", 1, 8, 1'b1);
        runCycle("chg", 2, 8, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'd4);
        runCycle("chg", 3, 8, 1'b1);
        checkOutput("chg.ready", {15'd0, cfg_ready}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int c = 4; c < 8; c++) begin
            runCycle("chg.pend", c, 8, 1'b1);
            checkOutput("chg.pend.ready", {15'd0, cfg_ready}, 16'd0);
        end
        runCycle("chg.new", 0, 4, 1'b1);
        checkOutput("chg.new.ready", {15'd0, cfg_ready}, 16'd1);
        for (int i = 1; i <= 8; i++) runCycle("div4", i % 4, 4, 1'b1);

        $display("[TB] transfer on wrap cycle");
        for (int c = 1; c < 4; c++) runCycle("wrapx", c, 4, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'd6);
        runCycle("wrapx", 0, 4, 1'b1);
        checkOutput("wrapx.ready", {15'd0, cfg_ready}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int c = 1; c < 4; c++) begin
            runCycle("wrapx.old", c, 4, 1'b1);
            checkOutput("wrapx.old.ready", {15'd0, cfg_ready}, 16'd0);
        end
        runCycle("div6", 0, 6, 1'b1);
        checkOutput("div6.ready", {15'd0, cfg_ready}, 16'd1);
        for (int c = 1; c < 6; c++) runCycle("div6", c, 6, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0);
        for (int c = 0; c < 6; c++) runCycle("div6.stop", c, 6, 1'b1);
        idleCycle("div6.idle");

        $display("[TB] ratio 3 loaded in IDLE");
        applyStimulus(1'b0, 1'b1, 16'd3);
        idleCycle("div3.load");
        checkOutput("div3.ready", {15'd0, cfg_ready}, 16'd1);
        checkOutput("div3.err", {15'd0, cfg_err}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 7; i++) runCycle("div3", i % 3, 3, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0);
        runCycle("div3.stop", 1, 3, 1'b1);
        runCycle("div3.stop", 2, 3, 1'b1);
        idleCycle("div3.idle");

        $display("[TB] enable and transfer together in IDLE");
        applyStimulus(1'b1, 1'b1, 16'd5);
        for (int i = 0; i < 6; i++) begin
            runCycle("div5", i % 5, 5, 1'b1);
            applyStimulus(1'b1, 1'b0, 16'd0);
        end

        $display("[TB] maximum ratio");
        applyStimulus(1'b1, 1'b1, 16'hFFFF);
        runCycle("max", 1, 5, 1'b1);
        checkOutput("max.ready", {15'd0, cfg_ready}, 16'd0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int c = 2; c < 5; c++) runCycle("max.pend", c, 5, 1'b1);
        runCycle("max.new", 0, 65535, 1'b1);
        checkOutput("max.new.ready", {15'd0, cfg_ready}, 16'd1);
        runCycle("max.new", 1, 65535, 1'b1);

        $display("[TB] period count and reset with pending ratio");
        applyStimulus(1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        step();
        checkResetOutputs("rst1");
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'd2);
        runCycle("div2", 0, 2, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int i = 1; i <= 20; i++) runCycle("div2", i % 2, 2, 1'b1);
`ifdef DIV_CTRL_PERIOD_CNT_EN
        checkOutput("periods.ten", periods, 16'd10);
`endif
        applyStimulus(1'b1, 1'b1, 16'd5);
        runCycle("rst2.pend", 1, 2, 1'b1);
        checkOutput("rst2.pend.ready", {15'd0, cfg_ready}, 16'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        step();
        checkResetOutputs("rst2");
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 9; i++) runCycle("post.div8", i % 8, 8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
